// File: rtl/ifu_fetch_arbiter_pkg.sv
// Shared types and defaults for the two-way instruction fetch arbiter.
package ifu_fetch_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } arb_state_e;

  localparam logic WAY0 = 1'b0;
  localparam logic WAY1 = 1'b1;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/ifu_fetch_arbiter_if.sv
// Fetch-way, instruction-bus and status signals of the fetch arbiter.
// Perf counter outputs exist only when IFU_ARB_PERF_EN is defined.
interface ifu_fetch_arbiter_if
  import ifu_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              way0_req_i;
  logic [ADDR_W-1:0] way0_addr_i;
  logic              way1_req_i;
  logic [ADDR_W-1:0] way1_addr_i;
  logic              jumpFlag_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic              mem_dataOk_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              way0_dataOk_o;
  logic              way1_dataOk_o;
  logic [DATA_W-1:0] inst_o;
  logic              busy_o;
  logic              err_o;
`ifdef IFU_ARB_PERF_EN
  logic [31:0]       way0_grants_o;
  logic [31:0]       way1_grants_o;
  logic [31:0]       flush_cnt_o;

  modport slave (
    input  way0_req_i, way0_addr_i, way1_req_i, way1_addr_i, jumpFlag_i,
           mem_ack_i, mem_dataOk_i, mem_rdata_i,
    output mem_req_o, mem_addr_o, way0_dataOk_o, way1_dataOk_o, inst_o,
           busy_o, err_o, way0_grants_o, way1_grants_o, flush_cnt_o
  );

  modport master (
    output way0_req_i, way0_addr_i, way1_req_i, way1_addr_i, jumpFlag_i,
           mem_ack_i, mem_dataOk_i, mem_rdata_i,
    input  mem_req_o, mem_addr_o, way0_dataOk_o, way1_dataOk_o, inst_o,
           busy_o, err_o, way0_grants_o, way1_grants_o, flush_cnt_o
  );
`else
  modport slave (
    input  way0_req_i, way0_addr_i, way1_req_i, way1_addr_i, jumpFlag_i,
           mem_ack_i, mem_dataOk_i, mem_rdata_i,
    output mem_req_o, mem_addr_o, way0_dataOk_o, way1_dataOk_o, inst_o,
           busy_o, err_o
  );

  modport master (
    output way0_req_i, way0_addr_i, way1_req_i, way1_addr_i, jumpFlag_i,
           mem_ack_i, mem_dataOk_i, mem_rdata_i,
    input  mem_req_o, mem_addr_o, way0_dataOk_o, way1_dataOk_o, inst_o,
           busy_o, err_o
  );
`endif

endinterface

// File: rtl/ifu_rr_picker.sv
// Combinational two-way round-robin picker: on a tie the way not granted last wins.
module ifu_rr_picker
  import ifu_fetch_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant_id
);

  // Grant selection
  always_comb begin
    o_grant_valid = i_req0 | i_req1;
    o_grant_id    = WAY0;
    if (i_req0 && i_req1) begin
      o_grant_id = ~i_last_grant;
    end else if (i_req1) begin
      o_grant_id = WAY1;
    end else begin
      o_grant_id = WAY0;
    end
  end

endmodule

// File: rtl/ifu_fetch_arbiter.sv
// Shares one instruction-bus read port between two fetch ways, one transaction at a time,
// with jump flush and a WAIT/DISCARD watchdog. Perf counters under IFU_ARB_PERF_EN.
module ifu_fetch_arbiter
  import ifu_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                clk,
  input logic                reset_n,
  ifu_fetch_arbiter_if.slave bus
);

  localparam int              CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_way0_ok;
  logic              r_way1_ok;
  logic [DATA_W-1:0] r_inst;
  logic              r_busy;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_grant_valid;
  logic              w_grant_id;
  logic [ADDR_W-1:0] w_grant_addr;
  logic              w_grant;
  logic              w_deliver;
  logic              w_timeout;
  logic              w_flush;
  logic              w_cnt_clr;

  ifu_rr_picker u_picker (
    .i_req0        (bus.way0_req_i),
    .i_req1        (bus.way1_req_i),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  assign w_grant_addr = (w_grant_id == WAY1) ? bus.way1_addr_i : bus.way0_addr_i;

  // Next-state and transaction event decode
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_deliver   = 1'b0;
    w_timeout   = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid && !bus.jumpFlag_i) begin
          w_grant     = 1'b1;
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        if (bus.jumpFlag_i) begin
          w_flush     = 1'b1;
          w_state_nxt = bus.mem_ack_i ? DISCARD : IDLE;
        end else if (bus.mem_ack_i) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = REQ;
        end
      end
      WAIT: begin
        if (bus.mem_dataOk_i) begin
          w_deliver   = ~bus.jumpFlag_i;
          w_state_nxt = IDLE;
        end else if (bus.jumpFlag_i) begin
          w_flush     = 1'b1;
          w_state_nxt = DISCARD;
        end else if (r_cnt == TIMEOUT_C) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      DISCARD: begin
        if (bus.mem_dataOk_i) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == TIMEOUT_C) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DISCARD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Watchdog restarts on every fresh entry into WAIT or DISCARD
  always_comb begin
    w_cnt_clr = 1'b0;
    if ((w_state_nxt == WAIT || w_state_nxt == DISCARD) && (w_state_nxt != r_state)) begin
      w_cnt_clr = 1'b1;
    end else begin
      w_cnt_clr = 1'b0;
    end
  end

  // State, arbitration history and owner
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= WAY1;
      r_owner      <= WAY0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_grant) begin
        r_last_grant <= w_grant_id;
        r_owner      <= w_grant_id;
      end else begin
        r_last_grant <= r_last_grant;
        r_owner      <= r_owner;
      end
    end
  end

  // Bus request side: address latched at grant, held through REQ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= {ADDR_W{1'b0}};
    end else begin
      r_mem_req <= (w_state_nxt == REQ);
      if (w_grant) begin
        r_mem_addr <= w_grant_addr;
      end else begin
        r_mem_addr <= r_mem_addr;
      end
    end
  end

  // Response side: one-cycle pulse to the owner, instruction held between pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_way0_ok <= 1'b0;
      r_way1_ok <= 1'b0;
      r_inst    <= {DATA_W{1'b0}};
    end else begin
      r_way0_ok <= w_deliver && (r_owner == WAY0);
      r_way1_ok <= w_deliver && (r_owner == WAY1);
      if (w_deliver) begin
        r_inst <= bus.mem_rdata_i;
      end else begin
        r_inst <= r_inst;
      end
    end
  end

  // Watchdog counter and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= {CNT_W{1'b0}};
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_timeout;
      if (w_cnt_clr) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (r_state == WAIT || r_state == DISCARD) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign bus.mem_req_o     = r_mem_req;
  assign bus.mem_addr_o    = r_mem_addr;
  assign bus.way0_dataOk_o = r_way0_ok;
  assign bus.way1_dataOk_o = r_way1_ok;
  assign bus.inst_o        = r_inst;
  assign bus.busy_o        = r_busy;
  assign bus.err_o         = r_err;

`ifdef IFU_ARB_PERF_EN
  logic [31:0] r_way0_grants;
  logic [31:0] r_way1_grants;
  logic [31:0] r_flush_cnt;

  // Free-running wrap-around performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_way0_grants <= 32'd0;
      r_way1_grants <= 32'd0;
      r_flush_cnt   <= 32'd0;
    end else begin
      r_way0_grants <= r_way0_grants + {31'd0, (w_grant && (w_grant_id == WAY0))};
      r_way1_grants <= r_way1_grants + {31'd0, (w_grant && (w_grant_id == WAY1))};
      r_flush_cnt   <= r_flush_cnt + {31'd0, w_flush};
    end
  end

  assign bus.way0_grants_o = r_way0_grants;
  assign bus.way1_grants_o = r_way1_grants;
  assign bus.flush_cnt_o   = r_flush_cnt;
`endif

endmodule
